lsu: RTL and testbench

Load/store unit for the npc-riscv64 core. Sits between the execute stage and data memory: it consumes the `mem_r` / `mem_w` strobes from the main control decoder, along with funct3, the ALU-computed address and rs2 data. It runs one aligned 64-bit transaction on the data-memory bus with a req/ack handshake. For loads it returns the sign- or zero-extended result for the `mem2reg` writeback path; for stores it builds the byte strobes.

---
 rtl/lsu.sv | 170 +++++++++++++++++
 tb/tb_lsu.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: runs one aligned 64-bit data-memory transaction per
// accepted start, using a req/ack handshake with a wait-cycle timeout.
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; launch is decoded and checked here
// BUS     | mem_req held high with stable mem_* until ack or timeout
// RESP    | one-cycle done pulse; rdata/err already registered
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   start, mem_r, mem_w      launch pulse and direction from control
//   funct3, addr, wdata      width/sign code, byte address, store data
//   busy, done, err, rdata   status and extended load result
//   mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb   bus request side
//   mem_ack, mem_rdata       bus response side
module lsu #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        mem_r,
   input  logic        mem_w,
   input  logic [2:0]  funct3,
   input  logic [63:0] addr,
   input  logic [63:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [63:0] rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wstrb,
   input  logic        mem_ack,
   input  logic [63:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

   state_t        state, state_n;
   logic [CW-1:0] cnt;
   logic [2:0]    f3_q;
   logic [2:0]    off_q;

   logic          misalign;
   logic          illegal;
   logic          req_any;
   logic [63:0]   wmask;
   logic [7:0]    strb_base;
   logic [63:0]   st_data;
   logic [7:0]    st_strb;
   logic [63:0]   ld_lane;
   logic [63:0]   ld_ext;
   logic          timeout_hit;

   assign busy        = (state != IDLE);
   assign done        = (state == RESP);
   assign mem_req     = (state == BUS);
   assign req_any     = mem_r | mem_w;
   assign timeout_hit = (cnt == CNT_LAST);

   always_comb begin
      misalign  = 1'b0;
      wmask     = 64'hFF;
      strb_base = 8'h01;
      case (funct3[1:0])
         2'd1: begin
            misalign  = addr[0];
            wmask     = 64'hFFFF;
            strb_base = 8'h03;
         end
         2'd2: begin
            misalign  = |addr[1:0];
            wmask     = 64'hFFFF_FFFF;
            strb_base = 8'h0F;
         end
         2'd3: begin
            misalign  = |addr[2:0];
            wmask     = '1;
            strb_base = 8'hFF;
         end
         default: ;
      endcase
      illegal = (mem_r & mem_w) | (mem_w & funct3[2]) |
                (mem_r & (funct3 == 3'b111)) | misalign;
      st_data = (wdata & wmask) << {addr[2:0], 3'b000};
      st_strb = strb_base << addr[2:0];
   end

   // Extraction works on the offset/code latched at launch, so the execute
   // stage is free to move on while the bus is outstanding.
   always_comb begin
      ld_lane = mem_rdata >> {off_q, 3'b000};
      ld_ext  = ld_lane;
      case (f3_q)
         3'b000:  ld_ext = {{56{ld_lane[7]}},  ld_lane[7:0]};
         3'b001:  ld_ext = {{48{ld_lane[15]}}, ld_lane[15:0]};
         3'b010:  ld_ext = {{32{ld_lane[31]}}, ld_lane[31:0]};
         3'b100:  ld_ext = {56'd0, ld_lane[7:0]};
         3'b101:  ld_ext = {48'd0, ld_lane[15:0]};
         3'b110:  ld_ext = {32'd0, ld_lane[31:0]};
         default: ld_ext = ld_lane;
      endcase
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (start && req_any) state_n = illegal ? RESP : BUS;
         BUS:  if (mem_ack || timeout_hit) state_n = RESP;
         RESP: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         f3_q      <= '0;
         off_q     <= '0;
         err       <= 1'b0;
         rdata     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (start && req_any) begin
                  if (illegal) begin
                     err   <= 1'b1;
                     rdata <= '0;
                  end else begin
                     f3_q      <= funct3;
                     off_q     <= addr[2:0];
                     mem_we    <= mem_w;
                     mem_addr  <= {addr[63:3], 3'b000};
                     mem_wdata <= st_data;
                     mem_wstrb <= mem_w ? st_strb : 8'h00;
                  end
               end
            end
            BUS: begin
               // Ack on the last counted cycle still completes normally.
               if (mem_ack) begin
                  err   <= 1'b0;
                  rdata <= mem_we ? 64'd0 : ld_ext;
               end else if (timeout_hit) begin
                  err   <= 1'b1;
                  rdata <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst, start, mem_r, mem_w;
   logic [2:0]  funct3;
   logic [63:0] addr, wdata;
   logic        busy, done, err;
   logic [63:0] rdata;
   logic        mem_req, mem_we;
   logic [63:0] mem_addr, mem_wdata;
   logic [7:0]  mem_wstrb;
   logic        mem_ack;
   logic [63:0] mem_rdata;

   int checks = 0;
   int failures = 0;

   lsu #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .mem_r(mem_r), .mem_w(mem_w),
      .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
      .err(err), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          r, w;
      logic [2:0]  f3;
      logic [63:0] a, wd, md;
      int          ack_at;   // cycle after start that ack is driven; 0 = never
      int          extra;    // cycle after start with a second start pulse; 0 = none
      int          e_done;   // expected done cycle; 0 = no done at all
      bit          e_err;
      logic [63:0] e_rd, e_ma, e_mwd;
      logic [7:0]  e_ms;
      int          e_req;
   } vec_t;

   typedef struct {
      int          ndone, done_at, req;
      bit          e, mwe, unstable;
      logic [63:0] rd, ma, mwd;
      logic [7:0]  ms;
   } obs_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(bit r, bit w, logic [2:0] f3, logic [63:0] a, logic [63:0] wd,
                               logic [63:0] md, int ack_at, int extra, int e_done, bit e_err,
                               logic [63:0] e_rd, logic [63:0] e_ma, logic [63:0] e_mwd,
                               logic [7:0] e_ms, int e_req);
      vec_t v;
      v.r = r; v.w = w; v.f3 = f3; v.a = a; v.wd = wd; v.md = md;
      v.ack_at = ack_at; v.extra = extra; v.e_done = e_done; v.e_err = e_err;
      v.e_rd = e_rd; v.e_ma = e_ma; v.e_mwd = e_mwd; v.e_ms = e_ms; v.e_req = e_req;
      return v;
   endfunction

   // Reference: expected outcome from the access rules, in plain arithmetic.
   function automatic vec_t model(vec_t v);
      int          n, off;
      logic [63:0] mask, lane;
      bit          bad;
      vec_t        o;
      o = v;
      o.e_done = 0; o.e_err = 0; o.e_rd = 0; o.e_ma = 0; o.e_mwd = 0; o.e_ms = 0; o.e_req = 0;
      n    = 1 << v.f3[1:0];
      off  = int'(v.a[2:0]);
      mask = (n == 8) ? {64{1'b1}} : ((64'd1 << (8 * n)) - 64'd1);
      if (!v.r && !v.w) return o;
      bad = (v.r && v.w) || (v.w && v.f3[2]) || (v.r && v.f3 == 3'd7) || ((off % n) != 0);
      if (bad) begin
         o.e_done = 1;
         o.e_err  = 1;
         return o;
      end
      o.e_ma  = v.a - 64'(off);
      o.e_mwd = (v.wd & mask) << (8 * off);
      o.e_ms  = v.w ? 8'(((1 << n) - 1) << off) : 8'h00;
      if (v.ack_at >= 1 && v.ack_at <= TO) begin
         o.e_done = v.ack_at + 1;
         o.e_req  = v.ack_at;
         if (v.r) begin
            lane = (v.md >> (8 * off)) & mask;
            if (!v.f3[2] && n < 8 && lane[8 * n - 1]) lane = lane | ~mask;
            o.e_rd = lane;
         end
      end else begin
         o.e_done = TO + 1;
         o.e_req  = TO;
         o.e_err  = 1;
      end
      return o;
   endfunction

   task automatic txn(input vec_t v, output obs_t o);
      o.ndone = 0; o.done_at = 0; o.req = 0; o.e = 0; o.mwe = 0; o.unstable = 0;
      o.rd = 0; o.ma = 0; o.mwd = 0; o.ms = 0;
      mem_r = v.r; mem_w = v.w; funct3 = v.f3; addr = v.a; wdata = v.wd;
      mem_ack = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      addr = {$urandom, $urandom}; wdata = {$urandom, $urandom}; funct3 = 3'($urandom);
      for (int k = 1; k <= 10; k++) begin
         if (done) begin
            o.ndone++;
            if (o.ndone == 1) begin
               o.done_at = k; o.e = err; o.rd = rdata;
            end
         end
         if (mem_req) begin
            o.req++;
            if (o.req == 1) begin
               o.ma = mem_addr; o.mwd = mem_wdata; o.ms = mem_wstrb; o.mwe = mem_we;
            end else if (mem_addr != o.ma || mem_wdata != o.mwd || mem_wstrb != o.ms ||
                         mem_we != o.mwe) begin
               o.unstable = 1;
            end
         end
         start     = (k == v.extra);
         mem_ack   = (k == v.ack_at);
         mem_rdata = (k == v.ack_at) ? v.md : {$urandom, $urandom};
         step();
      end
      start = 1'b0; mem_ack = 1'b0;
   endtask

   task automatic compare(input string tag, input vec_t v, input obs_t o);
      chk({tag, ".ndone"}, 64'(o.ndone), (v.e_done != 0) ? 64'd1 : 64'd0);
      chk({tag, ".req_cycles"}, 64'(o.req), 64'(v.e_req));
      if (v.e_done != 0) begin
         chk({tag, ".done_at"}, 64'(o.done_at), 64'(v.e_done));
         chk({tag, ".err"}, 64'(o.e), 64'(v.e_err));
         chk({tag, ".rdata"}, o.rd, v.e_rd);
      end
      if (v.e_req > 0) begin
         chk({tag, ".mem_addr"}, o.ma, v.e_ma);
         chk({tag, ".mem_wstrb"}, 64'(o.ms), 64'(v.e_ms));
         chk({tag, ".mem_we"}, 64'(o.mwe), 64'(v.w));
         chk({tag, ".stable"}, 64'(o.unstable), 64'd0);
         if (v.w) chk({tag, ".mem_wdata"}, o.mwd, v.e_mwd);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".busy"}, 64'(busy), 64'd0);
      chk({tag, ".done"}, 64'(done), 64'd0);
      chk({tag, ".err"}, 64'(err), 64'd0);
      chk({tag, ".mem_req"}, 64'(mem_req), 64'd0);
      chk({tag, ".mem_we"}, 64'(mem_we), 64'd0);
      chk({tag, ".rdata"}, rdata, 64'd0);
      chk({tag, ".mem_addr"}, mem_addr, 64'd0);
      chk({tag, ".mem_wdata"}, mem_wdata, 64'd0);
      chk({tag, ".mem_wstrb"}, 64'(mem_wstrb), 64'd0);
   endtask

   initial begin
      vec_t tbl[13];
      vec_t v;
      obs_t o;
      int   hits;

      tbl[0]  = mk(1, 0, 3'd0, 64'h8000_0003, 64'd0, 64'h8000_0000, 1, 0,
                   2, 0, 64'hFFFF_FFFF_FFFF_FF80, 64'h8000_0000, 64'd0, 8'h00, 1);
      tbl[1]  = mk(1, 0, 3'd4, 64'h8000_0003, 64'd0, 64'h8000_0000, 1, 0,
                   2, 0, 64'h80, 64'h8000_0000, 64'd0, 8'h00, 1);
      tbl[2]  = mk(0, 1, 3'd1, 64'h8000_0006, 64'h1234, 64'd0, 1, 0,
                   2, 0, 64'd0, 64'h8000_0000, 64'h1234_0000_0000_0000, 8'hC0, 1);
      tbl[3]  = mk(1, 0, 3'd2, 64'h8000_0002, 64'd0, 64'd0, 1, 0,
                   1, 1, 64'd0, 64'd0, 64'd0, 8'h00, 0);
      tbl[4]  = mk(1, 1, 3'd3, 64'h8000_0000, 64'd0, 64'd0, 1, 0,
                   1, 1, 64'd0, 64'd0, 64'd0, 8'h00, 0);
      tbl[5]  = mk(1, 0, 3'd3, 64'h8000_0008, 64'd0, 64'h55, 0, 0,
                   5, 1, 64'd0, 64'h8000_0008, 64'd0, 8'h00, 4);
      tbl[6]  = mk(1, 0, 3'd6, 64'h8000_0004, 64'd0, 64'hF000_0001_DEAD_BEEF, 4, 2,
                   5, 0, 64'hF000_0001, 64'h8000_0000, 64'd0, 8'h00, 4);
      tbl[7]  = mk(0, 1, 3'd3, 64'h10, 64'h0123_4567_89AB_CDEF, 64'd0, 2, 0,
                   3, 0, 64'd0, 64'h10, 64'h0123_4567_89AB_CDEF, 8'hFF, 2);
      tbl[8]  = mk(0, 1, 3'd4, 64'h100, 64'hAA, 64'd0, 1, 0,
                   1, 1, 64'd0, 64'd0, 64'd0, 8'h00, 0);
      tbl[9]  = mk(1, 0, 3'd7, 64'h100, 64'd0, 64'd0, 1, 0,
                   1, 1, 64'd0, 64'd0, 64'd0, 8'h00, 0);
      tbl[10] = mk(0, 0, 3'd0, 64'h100, 64'd0, 64'd0, 1, 0,
                   0, 0, 64'd0, 64'd0, 64'd0, 8'h00, 0);
      tbl[11] = mk(1, 0, 3'd1, 64'h22, 64'd0, 64'h0000_0000_8001_0000, 3, 0,
                   4, 0, 64'hFFFF_FFFF_FFFF_8001, 64'h20, 64'd0, 8'h00, 3);
      tbl[12] = mk(0, 1, 3'd0, 64'h45, 64'hABCD, 64'd0, 1, 0,
                   2, 0, 64'd0, 64'h40, 64'h0000_CD00_0000_0000, 8'h20, 1);

      rst = 1'b1; start = 1'b0; mem_r = 1'b0; mem_w = 1'b0; funct3 = 3'd0;
      addr = 64'd0; wdata = 64'd0; mem_ack = 1'b0; mem_rdata = 64'd0;
      step();
      step();
      chk_zero("reset");
      rst = 1'b0;
      step();

      for (int i = 0; i < 13; i++) begin
         txn(tbl[i], o);
         compare($sformatf("vec%0d", i), tbl[i], o);
      end

      for (int i = 0; i < 150; i++) begin
         int kind;
         kind   = int'($urandom_range(0, 5));
         v.r    = (kind == 0 || kind == 2 || kind == 4) || (kind == 5 && $urandom_range(0, 1) == 1);
         v.w    = (kind == 1 || kind == 3) || (kind == 5 && $urandom_range(0, 1) == 1);
         v.f3   = 3'($urandom_range(0, 7));
         v.a    = {$urandom, $urandom};
         if ($urandom_range(0, 2) != 0) v.a = v.a & ~((64'd1 << v.f3[1:0]) - 64'd1);
         v.wd   = {$urandom, $urandom};
         v.md   = {$urandom, $urandom};
         v.ack_at = int'($urandom_range(0, 6));
         v.extra  = 0;
         v = model(v);
         txn(v, o);
         compare($sformatf("rnd%0d", i), v, o);
      end

      // Reset while a store is waiting on the bus; the ack arrives after reset.
      mem_r = 1'b0; mem_w = 1'b1; funct3 = 3'd3; addr = 64'h1238; wdata = 64'hFFFF;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("midrst.req_before", 64'(mem_req), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      mem_ack = 1'b1; mem_rdata = '1;
      chk_zero("midrst");
      hits = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         mem_ack = 1'b0;
         if (done || mem_req) hits++;
      end
      chk("midrst.late_activity", 64'(hits), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
